// File: rtl/ps_pkg.sv
// ============================================================================
// Module   : ps_pkg
// Brief    : Shared constants and lane-slicing helper for paralelo_serie_param.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ps_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;

  // Upper bounds for the generic lane slicer; callers size-cast the result.
  localparam int PS_MAX_BUS   = 1024;
  localparam int PS_MAX_WIDTH = 64;

  function automatic logic [PS_MAX_WIDTH-1:0] lane_slice(
    input logic [PS_MAX_BUS-1:0] bus,
    input int                    k,
    input int                    width
  );
    logic [PS_MAX_BUS-1:0]   shifted;
    logic [PS_MAX_WIDTH-1:0] mask;
    shifted = bus >> (k * width);
    mask    = {PS_MAX_WIDTH{1'b1}} >> (PS_MAX_WIDTH - width);
    return shifted[PS_MAX_WIDTH-1:0] & mask;
  endfunction

endpackage

`default_nettype wire

// File: rtl/paralelo_serie_param_lane_shift.sv
// ============================================================================
// Module   : ps_lane_shift
// Brief    : One lane's shift register; loads a word or the idle comma on frame
//            boundaries and shifts toward the serial output otherwise.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps_lane_shift
  import ps_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(K28_5),
  parameter bit               MSB_FIRST = 1'b1
) (
  input  logic             clk_8f,
  input  logic             reset,
  input  logic             load,
  input  logic             sel_idle,
  input  logic [WIDTH-1:0] word,
  output logic             ser_bit
);

  logic [WIDTH-1:0] r_sh;

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      r_sh <= IDLE_WORD;
    end else if (load) begin
      r_sh <= sel_idle ? IDLE_WORD : word;
    end else if (MSB_FIRST) begin
      r_sh <= {r_sh[WIDTH-2:0], 1'b0};
    end else begin
      r_sh <= {1'b0, r_sh[WIDTH-1:1]};
    end
  end

  // Line is held low while in reset regardless of register contents.
  assign ser_bit = reset & (MSB_FIRST ? r_sh[WIDTH-1] : r_sh[0]);

endmodule

`default_nettype wire

// File: rtl/paralelo_serie_param.sv
// ============================================================================
// Module   : paralelo_serie_param
// Brief    : Multi-lane parallel-to-serial converter with a one-entry holding
//            buffer and valid/ready handshake; sends IDLE_WORD when starved.
// Revision : 1.0
// ============================================================================
`default_nettype none

module paralelo_serie_param
  import ps_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               LANES     = 1,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(K28_5),
  parameter bit               MSB_FIRST = 1'b1
) (
  input  logic                   clk_8f,
  input  logic                   reset,
  input  logic [LANES*WIDTH-1:0] data_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic [LANES-1:0]       data_out,
  output logic                   frame_start,
  output logic                   idle_out
);

  localparam int                c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

  logic [c_cnt_w-1:0]     r_cnt;
  logic [LANES*WIDTH-1:0] r_buf;
  logic                   r_buf_full;
  logic                   r_idl;

  logic                   w_load;
  logic                   w_accept;
  logic                   w_sel_idle;
  logic [LANES*WIDTH-1:0] w_src;

  assign w_load      = (r_cnt == c_last);
  assign ready_out   = reset & (!r_buf_full | w_load);
  assign w_accept    = valid_in & ready_out;
  assign w_sel_idle  = !r_buf_full & !w_accept;
  // A buffered word always takes precedence over the bypass path.
  assign w_src       = r_buf_full ? r_buf : data_in;
  assign frame_start = (r_cnt == '0) & reset;
  assign idle_out    = r_idl;

  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_idl      <= 1'b1;
    end else begin
      r_cnt <= w_load ? '0 : r_cnt + c_cnt_w'(1);
      if (w_load) begin
        if (r_buf_full) begin
          r_idl <= 1'b0;
          if (w_accept) begin
            r_buf <= data_in;
          end else begin
            r_buf_full <= 1'b0;
          end
        end else begin
          r_idl <= !w_accept;
        end
      end else if (w_accept) begin
        r_buf      <= data_in;
        r_buf_full <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ps_lane_shift #(
      .WIDTH     (WIDTH),
      .IDLE_WORD (IDLE_WORD),
      .MSB_FIRST (MSB_FIRST)
    ) u_lane (
      .clk_8f   (clk_8f),
      .reset    (reset),
      .load     (w_load),
      .sel_idle (w_sel_idle),
      .word     (WIDTH'(lane_slice(PS_MAX_BUS'(w_src), k, WIDTH))),
      .ser_bit  (data_out[k])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_paralelo_serie_param.sv
// ============================================================================
// Module   : tb_paralelo_serie_param
// Brief    : Directed bench for a 1-lane MSB-first and a 2-lane LSB-first unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_paralelo_serie_param;

  logic        clk_8f = 1'b0;
  logic        rst_a, rst_b;
  logic [7:0]  din_a;
  logic        va;
  logic        ready_a, fs_a, idle_a;
  logic [0:0]  dout_a;
  logic [15:0] din_b;
  logic        vb;
  logic        ready_b, fs_b, idle_b;
  logic [1:0]  dout_b;

  int vectors    = 0;
  int miscompares = 0;
  int ph  = 0;
  int phb = 0;

  always #5 clk_8f = ~clk_8f;

  paralelo_serie_param #(
    .WIDTH(8), .LANES(1), .IDLE_WORD(8'hBC), .MSB_FIRST(1'b1)
  ) dut_a (
    .clk_8f(clk_8f), .reset(rst_a), .data_in(din_a), .valid_in(va),
    .ready_out(ready_a), .data_out(dout_a), .frame_start(fs_a), .idle_out(idle_a)
  );

  paralelo_serie_param #(
    .WIDTH(8), .LANES(2), .IDLE_WORD(8'hBC), .MSB_FIRST(1'b0)
  ) dut_b (
    .clk_8f(clk_8f), .reset(rst_b), .data_in(din_b), .valid_in(vb),
    .ready_out(ready_b), .data_out(dout_b), .frame_start(fs_b), .idle_out(idle_b)
  );

  task automatic step();
    @(posedge clk_8f);
    #1;
    ph  = (ph + 1) % 8;
    phb = (phb + 1) % 8;
  endtask

  task automatic test_reset();
    logic [7:0] idle;
    idle  = 8'hBC;
    rst_a = 1'b0; rst_b = 1'b0;
    va = 1'b1; din_a = 8'hFF;
    vb = 1'b0; din_b = 16'h0000;
    #1;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (dout_a !== 1'b0) begin miscompares++; $display("FAIL reset_dout cyc%0d: got %b want 0", i, dout_a); end
      vectors++;
      if (ready_a !== 1'b0) begin miscompares++; $display("FAIL reset_ready cyc%0d: got %b want 0", i, ready_a); end
      vectors++;
      if (fs_a !== 1'b0) begin miscompares++; $display("FAIL reset_fs cyc%0d: got %b want 0", i, fs_a); end
      vectors++;
      if (dout_b !== 2'b00) begin miscompares++; $display("FAIL reset_dout_b cyc%0d: got %b want 00", i, dout_b); end
    end
    va = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;
    ph = 0; phb = 0;
    #1;
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (dout_a[0] !== idle[7-ph]) begin miscompares++; $display("FAIL idle_bit i%0d: got %b want %b", i, dout_a[0], idle[7-ph]); end
      vectors++;
      if (fs_a !== (ph == 0)) begin miscompares++; $display("FAIL idle_fs i%0d: got %b want %b", i, fs_a, (ph == 0)); end
      vectors++;
      if (idle_a !== 1'b1) begin miscompares++; $display("FAIL idle_flag i%0d: got %b want 1", i, idle_a); end
      step();
    end
  endtask

  task automatic test_single_word();
    logic [7:0] w;
    w = 8'hA5;
    while (ph != 7) step();
    va = 1'b1; din_a = w;
    vectors++;
    if (ready_a !== 1'b1) begin miscompares++; $display("FAIL single_ready: got %b want 1", ready_a); end
    step();
    va = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (dout_a[0] !== w[7-ph]) begin miscompares++; $display("FAIL single_bit i%0d: got %b want %b", i, dout_a[0], w[7-ph]); end
      vectors++;
      if (idle_a !== 1'b0) begin miscompares++; $display("FAIL single_idle i%0d: got %b want 0", i, idle_a); end
      vectors++;
      if (fs_a !== (ph == 0)) begin miscompares++; $display("FAIL single_fs i%0d: got %b want %b", i, fs_a, (ph == 0)); end
      step();
    end
    vectors++;
    if ({dout_a[0], idle_a, fs_a} !== 3'b111) begin miscompares++; $display("FAIL single_resume: got %b want 111", {dout_a[0], idle_a, fs_a}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  words [3];
    logic [23:0] stream;
    logic        mfull, exp_rdy, acc;
    int          idx;
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    stream = 24'h010203;
    mfull = 1'b0; idx = 0;
    while (ph != 7) step();
    for (int c = 0; c < 25; c++) begin
      va    = (idx < 3);
      din_a = (idx < 3) ? words[idx] : 8'h00;
      exp_rdy = !mfull || (ph == 7);
      vectors++;
      if (ready_a !== exp_rdy) begin miscompares++; $display("FAIL b2b_ready c%0d: got %b want %b", c, ready_a, exp_rdy); end
      acc = va && exp_rdy;
      if (ph == 7) begin
        if (mfull) mfull = acc;
      end else if (acc) begin
        mfull = 1'b1;
      end
      if (acc) idx++;
      step();
      if (c < 24) begin
        vectors++;
        if (dout_a[0] !== stream[23-c]) begin miscompares++; $display("FAIL b2b_bit c%0d: got %b want %b", c, dout_a[0], stream[23-c]); end
        vectors++;
        if (idle_a !== 1'b0) begin miscompares++; $display("FAIL b2b_idle c%0d: got %b want 0", c, idle_a); end
      end
    end
    va = 1'b0;
    vectors++;
    if ({dout_a[0], idle_a} !== 2'b11) begin miscompares++; $display("FAIL b2b_resume: got %b want 11", {dout_a[0], idle_a}); end
  endtask

  task automatic test_mid_frame();
    logic [7:0] w0, w1, w;
    w0 = 8'h3C; w1 = 8'hC3;
    while (ph != 2) step();
    va = 1'b1; din_a = w0;
    vectors++;
    if (ready_a !== 1'b1) begin miscompares++; $display("FAIL mid_ready_first: got %b want 1", ready_a); end
    step();
    din_a = w1;
    while (ph != 7) begin
      vectors++;
      if (ready_a !== 1'b0) begin miscompares++; $display("FAIL mid_ready_held ph%0d: got %b want 0", ph, ready_a); end
      vectors++;
      if (idle_a !== 1'b1) begin miscompares++; $display("FAIL mid_idle_held ph%0d: got %b want 1", ph, idle_a); end
      step();
    end
    vectors++;
    if (ready_a !== 1'b1) begin miscompares++; $display("FAIL mid_ready_load: got %b want 1", ready_a); end
    step();
    va = 1'b0;
    for (int i = 0; i < 16; i++) begin
      w = (i < 8) ? w0 : w1;
      vectors++;
      if (dout_a[0] !== w[7-ph]) begin miscompares++; $display("FAIL mid_bit i%0d: got %b want %b", i, dout_a[0], w[7-ph]); end
      vectors++;
      if (idle_a !== 1'b0) begin miscompares++; $display("FAIL mid_idle i%0d: got %b want 0", i, idle_a); end
      step();
    end
    vectors++;
    if ({dout_a[0], idle_a} !== 2'b11) begin miscompares++; $display("FAIL mid_resume: got %b want 11", {dout_a[0], idle_a}); end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] idle;
    idle = 8'hBC;
    while (ph != 7) step();
    va = 1'b1; din_a = 8'hFF;
    step();
    va = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (dout_a[0] !== 1'b1) begin miscompares++; $display("FAIL rmid_ff_bit i%0d: got %b want 1", i, dout_a[0]); end
      step();
    end
    rst_a = 1'b0;
    #1;
    vectors++;
    if ({dout_a[0], ready_a, fs_a} !== 3'b000) begin miscompares++; $display("FAIL rmid_async: got %b want 000", {dout_a[0], ready_a, fs_a}); end
    step();
    vectors++;
    if ({dout_a[0], idle_a} !== 2'b01) begin miscompares++; $display("FAIL rmid_held: got %b want 01", {dout_a[0], idle_a}); end
    rst_a = 1'b1;
    ph = 0;
    #1;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (dout_a[0] !== idle[7-ph]) begin miscompares++; $display("FAIL rmid_idle_bit i%0d: got %b want %b", i, dout_a[0], idle[7-ph]); end
      vectors++;
      if ({fs_a, idle_a} !== {(ph == 0), 1'b1}) begin miscompares++; $display("FAIL rmid_flags i%0d: got %b want %b", i, {fs_a, idle_a}, {(ph == 0), 1'b1}); end
      step();
    end
  endtask

  task automatic test_two_lanes();
    logic [7:0] idle, w0, w1;
    idle = 8'hBC; w0 = 8'h01; w1 = 8'h80;
    while (phb != 0) step();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (dout_b !== {idle[phb], idle[phb]}) begin miscompares++; $display("FAIL lanes_idle i%0d: got %b want %b", i, dout_b, {idle[phb], idle[phb]}); end
      step();
    end
    while (phb != 7) step();
    vb = 1'b1; din_b = 16'h8001;
    vectors++;
    if (ready_b !== 1'b1) begin miscompares++; $display("FAIL lanes_ready: got %b want 1", ready_b); end
    step();
    vb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (dout_b !== {w1[phb], w0[phb]}) begin miscompares++; $display("FAIL lanes_bit i%0d: got %b want %b", i, dout_b, {w1[phb], w0[phb]}); end
      vectors++;
      if ({fs_b, idle_b} !== {(phb == 0), 1'b0}) begin miscompares++; $display("FAIL lanes_flags i%0d: got %b want %b", i, {fs_b, idle_b}, {(phb == 0), 1'b0}); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_mid_frame();
    test_reset_mid_word();
    test_two_lanes();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/paralelo_serie_param.md
Name: paralelo_serie_param

Overview:
- Parametrised parallel-to-serial converter for the PHY transmit path.
- Serialises LANES words of WIDTH bits each, one bit per clock per lane, on a single bit-rate clock.
- A one-entry holding buffer with a valid/ready handshake decouples the producer from frame alignment.
- Emits the IDLE_WORD comma whenever no data is available; it sits between the byte-striping logic and the line drivers.

Parameters:
- WIDTH, 8: bits per word; must be >= 2.
- LANES, 1: number of parallel serial lanes; all lanes share the frame timing.
- IDLE_WORD, 8'hBC: filler word sent when no data is available (K28.5 comma low byte); WIDTH bits, replicated on every lane.
- MSB_FIRST, 1: 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk_8f, input, 1: bit clock, WIDTH x word rate; all logic on the rising edge.
- reset, input, 1: reset is asynchronous and active-low.
- data_in, input, LANES*WIDTH: lane k occupies bits [k*WIDTH +: WIDTH].
- valid_in, input, 1: data_in is valid.
- ready_out, output, 1: block accepts data_in this cycle.
- data_out, output, LANES: serial bit per lane.
- frame_start, output, 1: high while the first bit of a word is on data_out.
- idle_out, output, 1: high for the whole word while IDLE_WORD is being sent.

Behaviour:
- State:
  - bit counter cnt, 0..WIDTH-1, $clog2(WIDTH) bits;
  - per-lane shift register sh[k], WIDTH bits;
  - holding buffer buf (LANES*WIDTH) plus flag buf_full;
  - idle flag idl.
- Reset (reset=0, asynchronous):
  - cnt=0, buf_full=0, buf=0;
  - every sh[k]=IDLE_WORD, idl=1;
  - data_out=0 for all lanes, forced combinationally while reset is low;
  - frame_start=0, ready_out=0.
- After reset release: the first bit on data_out is the first bit of IDLE_WORD, with cnt=0.
- Bit output:
  - data_out[k] = sh[k][WIDTH-1] if MSB_FIRST, else sh[k][0];
  - frame_start = (cnt==0) & reset.
- load = (cnt==WIDTH-1).
- ready_out = reset & (!buf_full | load).
- accept = valid_in & ready_out.
- On each rising edge with reset high:
  - cnt advances, wrapping WIDTH-1 -> 0.
  - If !load: sh[k] shifts one position toward the output end, zero fill.
  - If load and buf_full: sh <= buf, idl <= 0. If accept is also high, buf <= data_in and buf_full stays 1; otherwise buf_full <= 0.
  - If load and !buf_full and accept: bypass, sh <= data_in, idl <= 0, buf untouched.
  - If load and !buf_full and !accept: sh[k] <= IDLE_WORD, idl <= 1.
  - If !load and accept: buf <= data_in, buf_full <= 1.
- idle_out = idl.
- Latency:
  - Word accepted on a load edge via bypass: its first bit appears the cycle after that edge.
  - Word accepted mid-frame: its first bit appears at the next frame boundary.
  - With the buffer empty, worst case is WIDTH cycles.
- Throughput: valid_in held high gives continuous words with no IDLE gaps. ready_out is low for WIDTH-1 of every WIDTH cycles once buf is full.
- Backpressure: a producer holding valid_in while ready_out=0 must keep data_in stable; no word is ever dropped or duplicated.
- Reset mid-word: the partial word is abandoned and the buffer is discarded. After release, transmission restarts with IDLE_WORD at cnt=0.
- All lanes are loaded and shifted on the same edges. A lane never carries a different word index from another lane.

Decomposition:
- Package ps_pkg holds:
  - localparam K28_5 = 8'hBC, the default IDLE_WORD;
  - a lane-slice function returning data_in[k*WIDTH +: WIDTH].
- Sub-module ps_lane_shift (params WIDTH, IDLE_WORD, MSB_FIRST), generated LANES times:
  - inputs clk_8f, reset, load, sel_idle, word;
  - output bit.
- The counter, buffer and handshake live in the top module.

Test Plan:
- Reset held low 5 cycles with valid_in=1 -> data_out=0, ready_out=0, frame_start=0. Release -> data_out reads 1,0,1,1,1,1,0,0 repeating; frame_start every 8th cycle; idle_out=1.
- Single word 8'hA5 offered on a load cycle with the buffer empty -> next 8 bits are 1,0,1,0,0,1,0,1; idle_out=0; then IDLE resumes.
- valid_in=1 continuously with data 8'h01, 8'h02, 8'h03 -> 24 contiguous data bits with no IDLE; ready_out pulses once per frame after the first fill.
- Word 8'h3C offered at cnt=2, then 8'hC3 held pending -> 8'h3C starts at the next boundary; 8'hC3 is accepted on that load edge and follows directly.
- reset pulsed low at cnt=4 of word 8'hFF -> data_out=0 immediately; after release, a full IDLE_WORD at cnt=0; 8'hFF is not resumed.
- LANES=2, MSB_FIRST=0, data_in=16'h80_01 -> lane0 sends 1,0,0,0,0,0,0,0 and lane1 sends 0,0,0,0,0,0,0,1, aligned with frame_start.
